// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default-slave states and select-vector layout.
// Used by the response mux, its default slave and the bench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DF_IDLE = 2'b00,
    DF_ERR1 = 2'b01,
    DF_ERR2 = 2'b10
  } df_state_t;

  // Bit positions inside the registered select vector {DF,3,2,1}
  localparam int SEL_IDX_S1 = 0;
  localparam int SEL_IDX_S2 = 1;
  localparam int SEL_IDX_S3 = 2;
  localparam int SEL_IDX_DF = 3;

  localparam logic [3:0] SEL_S1 = 4'b0001;
  localparam logic [3:0] SEL_S2 = 4'b0010;
  localparam logic [3:0] SEL_S3 = 4'b0100;
  localparam logic [3:0] SEL_DF = 4'b1000;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_response_mux_if.sv
// Bundle between the address decoder / slaves and the AHB-Lite response mux.
// The slave modport is the mux view; master is the driver view.
interface ahb_response_mux_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL_1, HSEL_2, HSEL_3, HSEL_DF;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HRDATA_1, HRDATA_2, HRDATA_3;
  logic                  HREADYOUT_1, HREADYOUT_2, HREADYOUT_3;
  logic                  HRESP_1, HRESP_2, HRESP_3;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  HSEL_1, HSEL_2, HSEL_3, HSEL_DF, HTRANS,
    input  HRDATA_1, HRDATA_2, HRDATA_3,
    input  HREADYOUT_1, HREADYOUT_2, HREADYOUT_3,
    input  HRESP_1, HRESP_2, HRESP_3,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output HSEL_1, HSEL_2, HSEL_3, HSEL_DF, HTRANS,
    output HRDATA_1, HRDATA_2, HRDATA_3,
    output HREADYOUT_1, HREADYOUT_2, HREADYOUT_3,
    output HRESP_1, HRESP_2, HRESP_3,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle ERROR.
// AHB_MUX_ERRCNT_EN adds a saturating count of completed ERROR responses.
//
// state   | meaning
// DF_IDLE | not in an error data phase; zero-wait OKAY
// DF_ERR1 | first ERROR cycle, readyout low
// DF_ERR2 | second ERROR cycle, readyout high; next address phase accepted
module ahb_default_slave
  import ahb_pkg::*;
`ifdef AHB_MUX_ERRCNT_EN
  #(
    parameter int CNT_W = 8
  )
`endif
  (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL_DF,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
`ifdef AHB_MUX_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             readyout,
  output logic             resp
);

  df_state_t state;
  logic      accept;

  assign accept = HSEL_DF & HREADY & is_active(HTRANS);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= DF_IDLE;
      readyout <= 1'b1;
      resp     <= HRESP_OKAY;
    end else begin
      case (state)
        DF_IDLE: begin
          if (accept) begin
            state    <= DF_ERR1;
            readyout <= 1'b0;
            resp     <= HRESP_ERROR;
          end
        end
        DF_ERR1: begin
          state    <= DF_ERR2;
          readyout <= 1'b1;
          resp     <= HRESP_ERROR;
        end
        DF_ERR2: begin
          if (accept) begin
            state    <= DF_ERR1;
            readyout <= 1'b0;
            resp     <= HRESP_ERROR;
          end else begin
            state    <= DF_IDLE;
            readyout <= 1'b1;
            resp     <= HRESP_OKAY;
          end
        end
        default: begin
          state    <= DF_IDLE;
          readyout <= 1'b1;
          resp     <= HRESP_OKAY;
        end
      endcase
    end
  end

`ifdef AHB_MUX_ERRCNT_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_cnt <= '0;
    end else if (state == DF_ERR2 && err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ahb_response_mux.sv
// AHB-Lite data-phase return path: registers the one-hot HSEL at acceptance
// and steers the selected slave's response to the master. AHB_MUX_ERRCNT_EN adds DF_ERR_CNT.
module ahb_response_mux
  import ahb_pkg::*;
  #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] DF_RDATA   = '0
`ifdef AHB_MUX_ERRCNT_EN
    ,
    parameter int                    CNT_W      = 8
`endif
  ) (
  input  logic             HCLK,
  input  logic             HRESET,
`ifdef AHB_MUX_ERRCNT_EN
  output logic [CNT_W-1:0] DF_ERR_CNT,
`endif
  ahb_response_mux_if.slave bus
);

  logic [3:0] sel_d;
  logic [3:0] sel_q;
  logic       df_readyout;
  logic       df_resp;

  assign sel_d[SEL_IDX_S1] = bus.HSEL_1;
  assign sel_d[SEL_IDX_S2] = bus.HSEL_2;
  assign sel_d[SEL_IDX_S3] = bus.HSEL_3;
  assign sel_d[SEL_IDX_DF] = bus.HSEL_DF;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q <= SEL_DF;
    end else if (bus.HREADY) begin
      sel_q <= sel_d;
    end
  end

  ahb_default_slave
`ifdef AHB_MUX_ERRCNT_EN
    #(.CNT_W(CNT_W))
`endif
    u_default_slave (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL_DF  (bus.HSEL_DF),
    .HTRANS   (bus.HTRANS),
    .HREADY   (bus.HREADY),
`ifdef AHB_MUX_ERRCNT_EN
    .err_cnt  (DF_ERR_CNT),
`endif
    .readyout (df_readyout),
    .resp     (df_resp)
  );

  // A corrupted (non one-hot) select answers OKAY with no wait so the bus keeps moving
  always_comb begin
    bus.HRDATA = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = HRESP_OKAY;
    case (sel_q)
      SEL_S1: begin
        bus.HRDATA = bus.HRDATA_1;
        bus.HREADY = bus.HREADYOUT_1;
        bus.HRESP  = bus.HRESP_1;
      end
      SEL_S2: begin
        bus.HRDATA = bus.HRDATA_2;
        bus.HREADY = bus.HREADYOUT_2;
        bus.HRESP  = bus.HRESP_2;
      end
      SEL_S3: begin
        bus.HRDATA = bus.HRDATA_3;
        bus.HREADY = bus.HREADYOUT_3;
        bus.HRESP  = bus.HRESP_3;
      end
      SEL_DF: begin
        bus.HRDATA = DF_RDATA;
        bus.HREADY = df_readyout;
        bus.HRESP  = df_resp;
      end
      default: begin
        bus.HRDATA = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = HRESP_OKAY;
      end
    endcase
  end

endmodule
